// File: rtl/wb_retire_stage.sv
// wb_retire_stage: one-entry writeback/retire stage with sticky halt and retire counter
module wb_retire_stage #(
    parameter int DW = 16,
    parameter int RW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          M_v,
    output logic          M_ready,
    input  logic          M_wen,
    input  logic          M_halt,
    input  logic [RW-1:0] M_rt,
    input  logic [DW-1:0] M_data,
    input  logic          flush,
    input  logic          W_stall,
    output logic          W_v,
    output logic          W_wen,
    output logic [RW-1:0] W_rt,
    output logic [DW-1:0] W_data,
    output logic          isHalt,
    output logic [CW-1:0] W_count
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t        state_q;
    logic          occ_q, wen_q, halt_q;
    logic [RW-1:0] rt_q;
    logic [DW-1:0] data_q;
    logic [CW-1:0] count_q;
    logic          capture;
    assign W_v     = occ_q && !W_stall && state_q == RUN;
    assign M_ready = state_q == RUN && (!occ_q || W_v) && !(occ_q && halt_q);
    assign capture = M_v && M_ready && !flush;
    assign W_wen   = W_v && wen_q;
    assign W_rt    = occ_q ? rt_q : '0;
    assign W_data  = occ_q ? data_q : '0;
    assign isHalt  = state_q == HALTED;
    assign W_count = count_q;
    // Stage entry, run/halt state and retire counter; a retiring halt discards everything behind it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            occ_q   <= 1'b0;
            wen_q   <= 1'b0;
            halt_q  <= 1'b0;
            rt_q    <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            if (W_v) count_q <= count_q + 1'b1;
            if (W_v && halt_q) begin
                state_q <= HALTED;
                occ_q   <= 1'b0;
            end else if (capture) begin
                occ_q  <= 1'b1;
                wen_q  <= M_wen && !M_halt;
                halt_q <= M_halt;
                rt_q   <= M_rt;
                data_q <= M_data;
            end else if (W_v) begin
                occ_q <= 1'b0;
            end
        end
    end
endmodule
